// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array result path.
// Holds the drain FSM state type and index-width / beat-count helpers.
package systolic_pkg;

    typedef enum logic {
        IDLE,
        DRAIN
    } drain_state_t;

    // Index width for n entries; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int beats_of(input int rows, input int cols, input int lanes);
        return rows * cols / lanes;
    endfunction

endpackage

// File: rtl/systolic_result_drain_mux.sv
// Beat selector: picks LANES accumulators of row `row`, starting at column `col`.
// Ports: snap (flat snapshot), row, col in; data (LANES*OP_WIDTH, lane 0 at LSB) out.
module drain_beat_mux
    import systolic_pkg::*;
#(
    parameter int ROWS     = 64,
    parameter int COLS     = 64,
    parameter int OP_WIDTH = 32,
    parameter int LANES    = 8
) (
    input  logic [ROWS*COLS*OP_WIDTH-1:0] snap,
    input  logic [idx_w(ROWS)-1:0]        row,
    input  logic [idx_w(COLS)-1:0]        col,
    output logic [LANES*OP_WIDTH-1:0]     data
);

    logic [31:0] base;

    always_comb begin
        base = (32'(row) * 32'(COLS) + 32'(col)) * 32'(OP_WIDTH);
        data = snap[base +: LANES*OP_WIDTH];
    end

endmodule

// File: rtl/systolic_result_drain.sv
// Snapshots the accumulator matrix on compute_done and streams it row-major.
// Ports: clk/rst, compute_done + output_matrix in; m_* valid/ready stream out;
// busy, drain_done, overrun, overrun_count status out; clear_err in.
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int ROWS      = 64,
    parameter int COLS      = 64,
    parameter int OP_WIDTH  = 32,
    parameter int LANES     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          compute_done,
    input  logic [ROWS*COLS*OP_WIDTH-1:0] output_matrix,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [LANES*OP_WIDTH-1:0]     m_data,
    output logic [idx_w(ROWS)-1:0]        m_row,
    output logic [idx_w(COLS)-1:0]        m_col,
    output logic                          m_last,
    output logic                          busy,
    output logic                          drain_done,
    output logic                          overrun,
    output logic [CNT_WIDTH-1:0]          overrun_count,
    input  logic                          clear_err
);

    localparam int BEATS     = beats_of(ROWS, COLS, LANES);
    localparam int ROW_IDX_W = idx_w(ROWS);
    localparam int COL_IDX_W = idx_w(COLS);
    localparam int BEAT_W    = idx_w(BEATS);
    localparam int BEAT_DW   = LANES * OP_WIDTH;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    generate
        if (COLS % LANES != 0) begin : g_lanes_chk
            $error("systolic_result_drain: COLS must be a multiple of LANES");
        end
    endgenerate

    drain_state_t state_q, state_d;

    logic                          done_q;
    logic [BEAT_W-1:0]             beat_q, beat_d;
    logic [ROW_IDX_W-1:0]          nxt_row, row_d;
    logic [COL_IDX_W-1:0]          nxt_col, col_d;
    logic [BEAT_DW-1:0]            data_d, mux_data;
    logic                          valid_d, last_d, drain_done_d;
    logic [ROWS*COLS*OP_WIDTH-1:0] snap;

    logic rise, hs, final_hs, capture, ovr_evt;

    assign rise     = compute_done & ~done_q;
    assign hs       = m_valid & m_ready;
    assign final_hs = hs & m_last;
    // A completion landing on the final handshake reuses the buffer at once.
    assign capture  = rise & ((state_q == IDLE) | final_hs);
    assign ovr_evt  = rise & (state_q == DRAIN) & ~final_hs;
    assign busy     = (state_q == DRAIN);

    // Data-only storage; contents are meaningless until the first capture.
    always_ff @(posedge clk) begin
        if (capture) snap <= output_matrix;
    end

    // Successor of the current beat position.
    always_comb begin
        nxt_row = m_row;
        nxt_col = m_col + COL_IDX_W'(LANES);
        if (32'(m_col) + 32'(LANES) == 32'(COLS)) begin
            nxt_col = '0;
            nxt_row = m_row + ROW_IDX_W'(1);
        end
    end

    drain_beat_mux #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .OP_WIDTH (OP_WIDTH),
        .LANES    (LANES)
    ) u_beat_mux (
        .snap (snap),
        .row  (nxt_row),
        .col  (nxt_col),
        .data (mux_data)
    );

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        row_d        = m_row;
        col_d        = m_col;
        data_d       = m_data;
        valid_d      = m_valid;
        last_d       = m_last;
        drain_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = DRAIN;
                    beat_d  = '0;
                    row_d   = '0;
                    col_d   = '0;
                    // Snapshot is written on this same edge, so beat 0
                    // comes straight from the live matrix.
                    data_d  = output_matrix[BEAT_DW-1:0];
                    valid_d = 1'b1;
                    last_d  = (LAST_BEAT == '0);
                end
            end
            DRAIN: begin
                if (hs) begin
                    if (m_last) begin
                        drain_done_d = 1'b1;
                        beat_d       = '0;
                        row_d        = '0;
                        col_d        = '0;
                        if (rise) begin
                            data_d  = output_matrix[BEAT_DW-1:0];
                            valid_d = 1'b1;
                            last_d  = (LAST_BEAT == '0);
                        end else begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                        row_d  = nxt_row;
                        col_d  = nxt_col;
                        data_d = mux_data;
                        last_d = (beat_d == LAST_BEAT);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            beat_q     <= '0;
            m_row      <= '0;
            m_col      <= '0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            drain_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= compute_done;
            beat_q     <= beat_d;
            m_row      <= row_d;
            m_col      <= col_d;
            m_data     <= data_d;
            m_valid    <= valid_d;
            m_last     <= last_d;
            drain_done <= drain_done_d;
        end
    end

    // A fresh overrun outranks a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun       <= 1'b0;
            overrun_count <= '0;
        end else if (ovr_evt) begin
            overrun <= 1'b1;
            if (clear_err) overrun_count <= CNT_WIDTH'(1);
            else if (overrun_count != '1) overrun_count <= overrun_count + CNT_WIDTH'(1);
        end else if (clear_err) begin
            overrun       <= 1'b0;
            overrun_count <= '0;
        end
    end

endmodule
